// File: rtl/clock_meas.sv
`default_nettype none
// ============================================================================
// Module   : clock_meas
// Brief    : Measures period and high time of a slow input in clk_i cycles,
//            with lock detection and stall timeout.
// Revision : 1.0
// ============================================================================
module clock_meas #(
  parameter int CNT_WIDTH       = 16,
  parameter int EXPECTED_PERIOD = 100,
  parameter int TOLERANCE       = 1,
  parameter int LOCK_COUNT      = 4,
  parameter int TIMEOUT         = 65535
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 sig_i,
  input  logic                 enable_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 valid_o,
  output logic                 locked_o,
  output logic                 timeout_o
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_ONE = {{(MATCH_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
  localparam logic [31:0] MATCH_LO =
    (EXPECTED_PERIOD > TOLERANCE) ? (EXPECTED_PERIOD - TOLERANCE) : 0;
  localparam logic [31:0] MATCH_HI = EXPECTED_PERIOD + TOLERANCE;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  logic                 s1_q, s1_d;
  logic                 s2_q, s2_d;
  logic                 s3_q, s3_d;
  logic [0:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 timeout_q, timeout_d;
  logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;

  logic                 rise;
  logic [31:0]          period_ext;
  logic                 period_match;

  assign rise = s2_q & ~s3_q;

  // Window compare in a wide unsigned domain so EXPECTED_PERIOD-TOLERANCE never wraps.
  assign period_ext   = 32'(period_cnt_q);
  assign period_match = (period_ext >= MATCH_LO) && (period_ext <= MATCH_HI);

  always_comb begin
    s1_d         = sig_i;
    s2_d         = s1_q;
    s3_d         = s2_q;
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    valid_d      = 1'b0;
    locked_d     = locked_q;
    timeout_d    = timeout_q;
    match_cnt_d  = match_cnt_q;

    if (!enable_i) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      match_cnt_d  = '0;
      locked_d     = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          period_cnt_d = '0;
          high_cnt_d   = '0;
          if (rise) begin
            state_d      = MEASURE;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
            timeout_d    = 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d     = period_cnt_q;
            high_d       = high_cnt_q;
            valid_d      = 1'b1;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
            if (period_match) begin
              if (match_cnt_q != MATCH_MAX) begin
                match_cnt_d = match_cnt_q + MATCH_ONE;
              end
            end else begin
              match_cnt_d = '0;
            end
            locked_d = (match_cnt_d == MATCH_MAX);
          end else if (period_cnt_q == TIMEOUT_CNT) begin
            // Stalled input: drop back to IDLE and wait for a fresh arming edge.
            state_d      = IDLE;
            period_cnt_d = '0;
            high_cnt_d   = '0;
            timeout_d    = 1'b1;
            locked_d     = 1'b0;
            match_cnt_d  = '0;
          end else begin
            period_cnt_d = period_cnt_q + CNT_ONE;
            if (s2_q) begin
              high_cnt_d = high_cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      state_q      <= IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      match_cnt_q  <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
      match_cnt_q  <= match_cnt_d;
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign locked_o  = locked_q;
  assign timeout_o = timeout_q;

endmodule
`default_nettype wire
